// File: rtl/sram_responder.sv
// Single-port SRAM responder for a fixed byte window, with a backdoor preload port
// and counters for in-window reads and out-of-window accesses.
module sram_responder #(
    parameter int unsigned WORD_AW   = 10,
    parameter logic [31:0] BASE_ADDR = 32'hbfc00000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sram_en,
    input  logic [3:0]         sram_wen,
    input  logic [31:0]        sram_addr,
    input  logic [31:0]        sram_wdata,
    output logic [31:0]        sram_rdata,
    input  logic               ld_en,
    input  logic [WORD_AW-1:0] ld_addr,
    input  logic [31:0]        ld_data,
    output logic               err_flag,
    output logic [15:0]        err_cnt,
    output logic [31:0]        rd_cnt
);

    localparam int unsigned DEPTH = 1 << WORD_AW;

    logic [31:0]        mem [DEPTH];
    logic               hit;
    logic [WORD_AW-1:0] idx;
    logic               access;
    logic               rd_hit;
    logic               wr_hit;
    logic               miss;
    logic               addr_unused;

    always_comb begin
        hit         = (sram_addr[31:WORD_AW+2] == BASE_ADDR[31:WORD_AW+2]);
        idx         = sram_addr[WORD_AW+1:2];
        access      = sram_en && !reset;
        rd_hit      = access && hit && (sram_wen == 4'h0);
        wr_hit      = access && hit && (sram_wen != 4'h0);
        miss        = access && !hit;
        addr_unused = ^sram_addr[1:0];
    end

    // Preload is applied first so enabled write lanes override it on a shared index.
    always_ff @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        if (wr_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sram_wen[i])
                    mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    // Reads return the word as it stood before this edge's write or preload.
    always_ff @(posedge clk) begin
        if (reset)
            sram_rdata <= '0;
        else if (sram_en)
            sram_rdata <= hit ? mem[idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
            rd_cnt   <= '0;
        end else begin
            if (miss) begin
                err_flag <= 1'b1;
                if (err_cnt != 16'hffff)
                    err_cnt <= err_cnt + 16'd1;
            end
            if (rd_hit)
                rd_cnt <= rd_cnt + 32'd1;
        end
    end

endmodule
